// File: rtl/pci_target_mem_burst.sv
// rtl/pci_target_mem_burst.sv - PCI target burst memory behind one BAR window
// Purpose: claims word addresses add_start..add_end, inserts WAIT_STATES wait
//   cycles after DEVSEL, then runs data phases with an auto-incrementing word
//   address. Disconnects with STOP (no data) after a transfer at add_end.
// Ports:
//   clk, rst_n             rising-edge clock, synchronous active-low reset
//   frame_n, irdy_n        active-low initiator frame / ready
//   we                     direction, sampled with the address (1 = write)
//   add_in                 byte address, bits [1:0] ignored
//   add_start, add_end     inclusive claimed word-address window
//   data_in, be            write data, active-high byte enables
//   data_out               registered read data
//   devsel, trdy, stop     active-low target responses
//   last_add               current word address equals add_end (WAIT/DATA)

module pci_target_mem_burst #(
  parameter int DEPTH        = 1024,
  parameter int IDX_W        = 10,
  parameter int WAIT_STATES  = 1,
  parameter bit BE_ZERO_FILL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_n,
  input  logic        irdy_n,
  input  logic        we,
  input  logic [31:0] add_in,
  input  logic [29:0] add_start,
  input  logic [29:0] add_end,
  input  logic [31:0] data_in,
  input  logic [3:0]  be,
  output logic [31:0] data_out,
  output logic        devsel,
  output logic        trdy,
  output logic        stop,
  output logic        last_add
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA, S_TURN} state_t;

  state_t           state_q, state_d;
  logic [29:0]      wa_q, wa_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             we_q, we_d;
  logic [3:0]       wait_q, wait_d;
  logic             devsel_q, devsel_d;
  logic             trdy_q, trdy_d;
  logic             stop_q, stop_d;
  logic [31:0]      data_out_q, data_out_d;
  logic [31:0]      mem_q [DEPTH];

  logic [29:0]      dec_wa;
  logic [29:0]      dec_off;
  logic             dec_hit;
  logic [IDX_W-1:0] rd_idx;
  logic             load_rd;
  logic             xfer;
  logic             mem_we;
  logic [31:0]      mem_old;
  logic [31:0]      mem_wdata;
  logic             unused_addr_bits;

  assign dec_wa  = add_in[31:2];
  assign dec_off = dec_wa - add_start;
  // Offset check guards a window wider than the backing memory.
  assign dec_hit = (dec_wa >= add_start) && (dec_wa <= add_end) &&
                   (dec_off < 30'(DEPTH));
  assign unused_addr_bits = ^add_in[1:0];

  assign xfer    = (state_q == S_DATA) && !trdy_q && !irdy_n;
  // Reset on the same edge as a transfer suppresses the write.
  assign mem_we  = xfer && we_q && rst_n;
  assign mem_old = mem_q[idx_q];

  always_comb begin
    mem_wdata = mem_old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        mem_wdata[8*i +: 8] = data_in[8*i +: 8];
      end else if (BE_ZERO_FILL) begin
        mem_wdata[8*i +: 8] = 8'h00;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wa_d       = wa_q;
    idx_d      = idx_q;
    we_d       = we_q;
    wait_d     = wait_q;
    devsel_d   = devsel_q;
    trdy_d     = trdy_q;
    stop_d     = stop_q;
    data_out_d = data_out_q;
    rd_idx     = idx_q;
    load_rd    = 1'b0;

    case (state_q)
      S_IDLE: begin
        devsel_d = 1'b1;
        trdy_d   = 1'b1;
        stop_d   = 1'b1;
        if (!frame_n) begin
          wa_d  = dec_wa;
          we_d  = we;
          idx_d = dec_off[IDX_W-1:0];
          if (dec_hit) begin
            devsel_d = 1'b0;
            wait_d   = 4'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              state_d = S_DATA;
              trdy_d  = 1'b0;
              rd_idx  = dec_off[IDX_W-1:0];
              load_rd = !we;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
      end

      S_WAIT: begin
        if (wait_q <= 4'd1) begin
          wait_d  = 4'd0;
          state_d = S_DATA;
          trdy_d  = 1'b0;
          load_rd = !we_q;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      S_DATA: begin
        if (!stop_q) begin
          // Disconnect pending: hold STOP until the initiator ends the frame.
          if (frame_n) begin
            state_d  = S_TURN;
            devsel_d = 1'b1;
            stop_d   = 1'b1;
          end
        end else if (xfer) begin
          if (frame_n) begin
            state_d  = S_TURN;
            trdy_d   = 1'b1;
            devsel_d = 1'b1;
          end else if (wa_q < add_end) begin
            wa_d    = wa_q + 30'd1;
            idx_d   = idx_q + IDX_W'(1);
            rd_idx  = idx_q + IDX_W'(1);
            load_rd = !we_q;
          end else begin
            trdy_d = 1'b1;
            stop_d = 1'b0;
          end
        end
      end

      S_TURN: begin
        devsel_d = 1'b1;
        trdy_d   = 1'b1;
        stop_d   = 1'b1;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load_rd) begin
      data_out_d = mem_q[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wa_q       <= 30'd0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      wait_q     <= 4'd0;
      devsel_q   <= 1'b1;
      trdy_q     <= 1'b1;
      stop_q     <= 1'b1;
      data_out_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      wa_q       <= wa_d;
      idx_q      <= idx_d;
      we_q       <= we_d;
      wait_q     <= wait_d;
      devsel_q   <= devsel_d;
      trdy_q     <= trdy_d;
      stop_q     <= stop_d;
      data_out_q <= data_out_d;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= mem_wdata;
    end
  end

  assign data_out = data_out_q;
  assign devsel   = devsel_q;
  assign trdy     = trdy_q;
  assign stop     = stop_q;
  assign last_add = ((state_q == S_WAIT) || (state_q == S_DATA)) &&
                    (wa_q == add_end);

endmodule

// File: tb/tb_pci_target_mem_burst.sv
// tb/tb_pci_target_mem_burst.sv - self-checking bench for pci_target_mem_burst
module tb_pci_target_mem_burst;

  localparam int WS = 1;

  logic        clk;
  logic        rst_n;
  logic        frame_n;
  logic        irdy_n;
  logic        we;
  logic [31:0] add_in;
  logic [29:0] add_start;
  logic [29:0] add_end;
  logic [31:0] data_in;
  logic [3:0]  be;
  logic [31:0] data_out,  data_out_zf;
  logic        devsel,    devsel_zf;
  logic        trdy,      trdy_zf;
  logic        stop,      stop_zf;
  logic        last_add,  last_add_zf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m0 [int];
  logic [31:0] m1 [int];
  logic [31:0] exp0 [$];
  logic [31:0] exp1 [$];
  logic [31:0] wbuf [8];
  logic [3:0]  bebuf [8];

  pci_target_mem_burst #(.DEPTH(1024), .IDX_W(10), .WAIT_STATES(WS), .BE_ZERO_FILL(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .frame_n(frame_n), .irdy_n(irdy_n), .we(we),
    .add_in(add_in), .add_start(add_start), .add_end(add_end),
    .data_in(data_in), .be(be), .data_out(data_out), .devsel(devsel),
    .trdy(trdy), .stop(stop), .last_add(last_add)
  );

  pci_target_mem_burst #(.DEPTH(1024), .IDX_W(10), .WAIT_STATES(WS), .BE_ZERO_FILL(1'b1)) u_dut_zf (
    .clk(clk), .rst_n(rst_n), .frame_n(frame_n), .irdy_n(irdy_n), .we(we),
    .add_in(add_in), .add_start(add_start), .add_end(add_end),
    .data_in(data_in), .be(be), .data_out(data_out_zf), .devsel(devsel_zf),
    .trdy(trdy_zf), .stop(stop_zf), .last_add(last_add_zf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_write(int w, logic [31:0] d, logic [3:0] b);
    logic [31:0] o0, n0, n1;
    o0 = m0.exists(w) ? m0[w] : 32'h0;
    n0 = o0;
    n1 = m1.exists(w) ? m1[w] : 32'h0;
    for (int i = 0; i < 4; i++) begin
      n0[8*i +: 8] = b[i] ? d[8*i +: 8] : o0[8*i +: 8];
      n1[8*i +: 8] = b[i] ? d[8*i +: 8] : 8'h00;
    end
    m0[w] = n0;
    m1[w] = n1;
  endfunction

  task automatic burst(input bit wr, input logic [31:0] addr, input int n,
                       input int hold_beat, input int rst_beat, input string tag);
    int beat, cyc, first_t, first_x, last_x, wa;
    bit held;
    logic [31:0] e0, e1;
    beat = 0; cyc = 0; first_t = -1; first_x = -1; last_x = -1; held = 0;
    wa = int'(addr[31:2]);
    if (!wr) begin
      for (int i = 0; i < n; i++) begin
        exp0.push_back(m0[wa + i]);
        exp1.push_back(m1[wa + i]);
      end
    end
    frame_n = 1'b0; we = wr; add_in = addr; irdy_n = 1'b1;
    tick();
    n_checks++;
    if (devsel !== 1'b0 || trdy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s decode: devsel=%b trdy=%b, required devsel=0 trdy=1", tag, devsel, trdy);
    end
    while (beat < n && cyc < 40) begin
      frame_n = (beat == n - 1);
      irdy_n  = (beat == hold_beat) && !held;
      data_in = wbuf[beat];
      be      = bebuf[beat];
      if (beat == rst_beat) begin
        rst_n = 1'b0;
        m0.delete(wa + beat);
        m1.delete(wa + beat);
        tick();
        rst_n = 1'b1; frame_n = 1'b1; irdy_n = 1'b1;
        n_checks++;
        if ({devsel, trdy, stop, last_add} !== 4'b1110 || data_out !== 32'h0) begin
          n_fail++;
          $display("FAIL %s reset_abort: devsel/trdy/stop/last_add=%b data_out=%h, required 1110 and 0",
                   tag, {devsel, trdy, stop, last_add}, data_out);
        end
        return;
      end
      if (trdy === 1'b0 && first_t < 0) begin
        first_t = cyc;
        n_checks++;
        if (first_t != WS) begin
          n_fail++;
          $display("FAIL %s latency: first trdy %0d cycles after decode, required %0d", tag, first_t + 1, WS + 1);
        end
      end
      if (trdy === 1'b0 && irdy_n === 1'b0) begin
        if (wr) begin
          model_write(wa + beat, wbuf[beat], bebuf[beat]);
        end else begin
          e0 = exp0.pop_front();
          e1 = exp1.pop_front();
          n_checks++;
          if (data_out !== e0 || data_out_zf !== e1) begin
            n_fail++;
            $display("FAIL %s read_beat%0d: data_out=%h/%h, required %h/%h", tag, beat, data_out, data_out_zf, e0, e1);
          end
        end
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
        beat++;
      end else if (trdy === 1'b0 && irdy_n === 1'b1 && beat == hold_beat) begin
        held = 1;
        if (!wr && exp0.size() > 0) begin
          n_checks++;
          if (data_out !== exp0[0]) begin
            n_fail++;
            $display("FAIL %s hold: data_out=%h, required %h", tag, data_out, exp0[0]);
          end
        end
      end
      tick();
      cyc++;
    end
    frame_n = 1'b1; irdy_n = 1'b1;
    n_checks++;
    if (beat != n) begin
      n_fail++;
      $display("FAIL %s timeout: %0d beats done, required %0d", tag, beat, n);
    end
    exp0.delete();
    exp1.delete();
    n_checks++;
    if (devsel !== 1'b1 || trdy !== 1'b1 || stop !== 1'b1) begin
      n_fail++;
      $display("FAIL %s release: devsel=%b trdy=%b stop=%b, required 1 1 1", tag, devsel, trdy, stop);
    end
    n_checks++;
    if (last_x - first_x != n - 1 + int'(held)) begin
      n_fail++;
      $display("FAIL %s streaming: %0d cycles first to last beat, required %0d", tag, last_x - first_x, n - 1 + int'(held));
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frame_n = 1'b1; irdy_n = 1'b1; we = 1'b0; add_in = '0;
    data_in = '0; be = '0; add_start = 30'h100; add_end = 30'h1FF;
    tick();
    tick();
    n_checks++;
    if ({devsel, trdy, stop, last_add} !== 4'b1110 || data_out !== 32'h0 || data_out_zf !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: devsel/trdy/stop/last_add=%b data_out=%h, required 1110 and 0",
               {devsel, trdy, stop, last_add}, data_out);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    wbuf[0] = 32'hDEADBEEF; bebuf[0] = 4'b1111;
    burst(1'b1, 32'h400, 1, -1, -1, "single_write");
    burst(1'b0, 32'h400, 1, -1, -1, "single_read");
  endtask

  task automatic test_partial_write();
    wbuf[0] = 32'h11223344; bebuf[0] = 4'b1111;
    burst(1'b1, 32'h404, 1, -1, -1, "preload_partial");
    wbuf[0] = 32'hAABBCCDD; bebuf[0] = 4'b0101;
    burst(1'b1, 32'h404, 1, -1, -1, "partial_write");
    burst(1'b0, 32'h404, 1, -1, -1, "partial_read");
  endtask

  task automatic test_read_burst_hold();
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 32'hC0DE0000 + 32'(i * 32'h1111);
      bebuf[i] = 4'b1111;
    end
    burst(1'b1, 32'h400, 4, -1, -1, "wr_burst4");
    burst(1'b0, 32'h400, 4, 1, -1, "rd_burst4_hold");
  endtask

  task automatic test_disconnect();
    int beat, cyc;
    logic [31:0] e0, e1;
    wbuf[0] = 32'h5A5A0001; wbuf[1] = 32'h5A5A0002;
    bebuf[0] = 4'b1111; bebuf[1] = 4'b1111;
    burst(1'b1, 32'h7F8, 2, -1, -1, "wr_edge");
    exp0.push_back(m0[32'h1FE]); exp0.push_back(m0[32'h1FF]);
    exp1.push_back(m1[32'h1FE]); exp1.push_back(m1[32'h1FF]);
    frame_n = 1'b0; we = 1'b0; add_in = 32'h7F8; irdy_n = 1'b1;
    tick();
    beat = 0; cyc = 0;
    while (beat < 2 && cyc < 20) begin
      irdy_n = 1'b0;
      if (trdy === 1'b0) begin
        e0 = exp0.pop_front();
        e1 = exp1.pop_front();
        n_checks++;
        if (data_out !== e0 || data_out_zf !== e1 || last_add !== (beat == 1)) begin
          n_fail++;
          $display("FAIL disc_beat%0d: data_out=%h last_add=%b, required %h last_add=%b",
                   beat, data_out, last_add, e0, beat == 1);
        end
        beat++;
      end
      tick();
      cyc++;
    end
    n_checks++;
    if (beat != 2) begin
      n_fail++;
      $display("FAIL disc_timeout: %0d beats, required 2", beat);
    end
    exp0.delete();
    exp1.delete();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({stop, trdy, devsel, last_add} !== 4'b0101) begin
        n_fail++;
        $display("FAIL disc_stop%0d: stop/trdy/devsel/last_add=%b, required 0101", k, {stop, trdy, devsel, last_add});
      end
      tick();
    end
    frame_n = 1'b1; irdy_n = 1'b1;
    tick();
    n_checks++;
    if ({stop, trdy, devsel, last_add} !== 4'b1110) begin
      n_fail++;
      $display("FAIL disc_turn: stop/trdy/devsel/last_add=%b, required 1110", {stop, trdy, devsel, last_add});
    end
    tick();
    n_checks++;
    if ({stop, trdy, devsel, last_add} !== 4'b1110) begin
      n_fail++;
      $display("FAIL disc_idle: stop/trdy/devsel/last_add=%b, required 1110", {stop, trdy, devsel, last_add});
    end
  endtask

  task automatic test_miss();
    logic [31:0] miss_addr [2];
    miss_addr[0] = 32'h3FC;
    miss_addr[1] = 32'h800;
    for (int m = 0; m < 2; m++) begin
      frame_n = 1'b0; we = 1'b1; add_in = miss_addr[m]; irdy_n = 1'b1;
      data_in = 32'hBAD0BAD0; be = 4'b1111;
      tick();
      frame_n = 1'b1; irdy_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (devsel !== 1'b1 || trdy !== 1'b1) begin
          n_fail++;
          $display("FAIL miss_%h cyc%0d: devsel=%b trdy=%b, required 1 1", miss_addr[m], k, devsel, trdy);
        end
        tick();
      end
      irdy_n = 1'b1;
    end
    burst(1'b0, 32'h400, 1, -1, -1, "miss_chk_lo");
    burst(1'b0, 32'h7FC, 1, -1, -1, "miss_chk_hi");
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 32'hA0A00000 + 32'(i);
      bebuf[i] = 4'b1111;
    end
    burst(1'b1, 32'h480, 4, -1, -1, "rst_preload");
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hB0B00000 + 32'(i);
    burst(1'b1, 32'h480, 4, -1, 1, "rst_burst");
    tick();
    burst(1'b0, 32'h480, 1, -1, -1, "rst_beat1");
    burst(1'b0, 32'h488, 2, -1, -1, "rst_beats34");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      wbuf[i] = $urandom;
      bebuf[i] = 4'($urandom_range(1, 15));
    end
    wbuf[3] = 32'h0; bebuf[3] = 4'b1111;
    burst(1'b1, 32'h500, 3, -1, -1, "b2b_pre");
    for (int i = 0; i < 3; i++) begin
      wbuf[i] = $urandom;
      bebuf[i] = 4'($urandom_range(0, 15));
    end
    burst(1'b1, 32'h500, 3, -1, -1, "b2b_wr");
    burst(1'b0, 32'h500, 3, -1, -1, "b2b_rd");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_partial_write();
    test_read_burst_hold();
    test_disconnect();
    test_miss();
    test_reset_mid_burst();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
